// File: rtl/ravan_pkg.sv
// ravan_pkg: types, constants and helpers shared by the RAVAN crypt core.
//   state_t      : FSM state encoding (IDLE, RUN, DONE)
//   MODE_ENC/DEC : per-block direction select
//   rotl/rotr    : rotate within the low w bits of a ROT_MAX_W-wide operand
package ravan_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  // Widest operand the rotate helpers handle. The caller zero-extends a
  // w-bit value into this width and truncates the result back to w bits;
  // bits shifted above position w-1 are discarded by that truncation.
  localparam int ROT_MAX_W = 1024;

  function automatic logic [ROT_MAX_W-1:0] rotl(input logic [ROT_MAX_W-1:0] x,
                                                input int unsigned w,
                                                input int unsigned r);
    return (x << r) | (x >> (w - r));
  endfunction

  function automatic logic [ROT_MAX_W-1:0] rotr(input logic [ROT_MAX_W-1:0] x,
                                                input int unsigned w,
                                                input int unsigned r);
    return (x >> r) | (x << (w - r));
  endfunction

endpackage

// File: rtl/ravan_round.sv
// ravan_round: one full cipher round, purely combinational.
//   state_in  : DATA_W block entering the round
//   key       : NUM_SLICES slices, slice i = key[i*DATA_W +: DATA_W]
//   mode      : MODE_ENC applies slices 0..N-1, MODE_DEC applies N-1..0
//   state_out : DATA_W block leaving the round
module ravan_round
  import ravan_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int NUM_SLICES = 8,
  parameter int ROT        = 13
) (
  input  logic [DATA_W-1:0]            state_in,
  input  logic [DATA_W*NUM_SLICES-1:0] key,
  input  logic                         mode,
  output logic [DATA_W-1:0]            state_out
);

  logic [DATA_W-1:0] t;
  logic [DATA_W-1:0] k;
  logic [DATA_W-1:0] u;
  logic [DATA_W-1:0] r;

  // u is computed at DATA_W first so the zero-extension into the rotate
  // helper never sees inverted upper bits.
  always_comb begin
    t = state_in;
    k = '0;
    u = '0;
    r = '0;
    if (mode == MODE_ENC) begin
      for (int i = 0; i < NUM_SLICES; i++) begin
        k = key[i*DATA_W +: DATA_W];
        u = ~(t ^ k);
        r = DATA_W'(rotl(ROT_MAX_W'(u), DATA_W, ROT));
        t = r + k;
      end
    end else begin
      for (int i = NUM_SLICES - 1; i >= 0; i--) begin
        k = key[i*DATA_W +: DATA_W];
        u = t - k;
        r = DATA_W'(rotr(ROT_MAX_W'(u), DATA_W, ROT));
        t = ~r ^ k;
      end
    end
    state_out = t;
  end

endmodule

// File: rtl/ravan_crypt_core.sv
// ravan_crypt_core: iterative encrypt/decrypt engine, one round per clock.
//   clk, rst_n           : clock, async active-low reset
//   in_valid/in_ready    : input handshake; in_data, key, in_mode captured on accept
//   out_valid/out_ready  : output handshake; out_data, out_mode held until taken
//   busy                 : high whenever a block is in flight or waiting
//
// state | meaning
// IDLE  | waiting for a block, in_ready=1
// RUN   | one round per cycle, rcnt counts 0..ROUNDS-1
// DONE  | result presented, waiting for out_ready
module ravan_crypt_core
  import ravan_pkg::*;
#(
  parameter  int DATA_W     = 64,
  parameter  int NUM_SLICES = 8,
  parameter  int ROUNDS     = 21,
  parameter  int ROT        = 13,
  localparam int KEY_W      = DATA_W * NUM_SLICES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_mode,
  input  logic [DATA_W-1:0] in_data,
  input  logic [KEY_W-1:0]  key,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_mode,
  output logic              busy
);

  localparam int RCNT_W = $clog2(ROUNDS) + 1;

  state_t              state_q, state_d;
  logic [RCNT_W-1:0]   rcnt_q;
  logic [DATA_W-1:0]   data_q;
  logic [KEY_W-1:0]    key_q;
  logic                mode_q;
  logic [DATA_W-1:0]   round_out;
  logic                accept;
  logic                last_round;

  ravan_round #(
    .DATA_W     (DATA_W),
    .NUM_SLICES (NUM_SLICES),
    .ROT        (ROT)
  ) u_round (
    .state_in  (data_q),
    .key       (key_q),
    .mode      (mode_q),
    .state_out (round_out)
  );

  assign accept     = in_valid && in_ready;
  assign last_round = (rcnt_q == RCNT_W'(ROUNDS - 1));

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        if (last_round) state_d = DONE;
      end
      DONE: begin
        // Handing off the result frees the core in the same cycle.
        if (out_ready) begin
          in_ready = 1'b1;
          state_d  = in_valid ? RUN : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rcnt_q  <= '0;
      data_q  <= '0;
      key_q   <= '0;
      mode_q  <= MODE_ENC;
    end else begin
      state_q <= state_d;
      if (accept) begin
        data_q <= in_data;
        key_q  <= key;
        mode_q <= in_mode;
        rcnt_q <= '0;
      end else if (state_q == RUN) begin
        data_q <= round_out;
        if (!last_round) rcnt_q <= rcnt_q + 1'b1;
      end
    end
  end

  assign out_valid = (state_q == DONE);
  assign out_data  = data_q;
  assign out_mode  = mode_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_ravan_crypt_core.sv
module tb_ravan_crypt_core;
  import ravan_pkg::*;

  localparam int DW = 64;
  localparam int NS = 8;
  localparam int RN = 21;
  localparam int RT = 13;
  localparam int KW = DW * NS;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, in_mode, out_valid, out_ready, out_mode, busy;
  logic [DW-1:0] in_data, out_data;
  logic [KW-1:0] key;

  logic          in_valid_1, in_ready_1, in_mode_1, out_valid_1, out_ready_1, out_mode_1, busy_1;
  logic [DW-1:0] in_data_1, out_data_1, key_1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ravan_crypt_core #(.DATA_W(DW), .NUM_SLICES(NS), .ROUNDS(RN), .ROT(RT)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_mode(in_mode), .in_data(in_data), .key(key), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_mode(out_mode), .busy(busy)
  );

  ravan_crypt_core #(.DATA_W(DW), .NUM_SLICES(1), .ROUNDS(1), .ROT(RT)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_1), .in_ready(in_ready_1),
    .in_mode(in_mode_1), .in_data(in_data_1), .key(key_1), .out_valid(out_valid_1),
    .out_ready(out_ready_1), .out_data(out_data_1), .out_mode(out_mode_1), .busy(busy_1)
  );

  // Reference model: the cipher written straight from its arithmetic definition.
  function automatic logic [63:0] rl(input logic [63:0] x, input int r);
    return (x << r) | (x >> (64 - r));
  endfunction

  function automatic logic [63:0] rr(input logic [63:0] x, input int r);
    return (x >> r) | (x << (64 - r));
  endfunction

  function automatic logic [63:0] ref_model(input logic [63:0] d, input logic [KW-1:0] k,
                                            input logic m);
    logic [63:0] t, s;
    t = d;
    for (int rd = 0; rd < RN; rd++) begin
      if (m == MODE_ENC) begin
        for (int i = 0; i < NS; i++) begin
          s = k[i*DW +: DW];
          t = rl(~(t ^ s), RT) + s;
        end
      end else begin
        for (int i = NS - 1; i >= 0; i--) begin
          s = k[i*DW +: DW];
          t = ~rr(t - s, RT) ^ s;
        end
      end
    end
    return t;
  endfunction

  function automatic logic [KW-1:0] rand_key();
    logic [KW-1:0] k;
    for (int i = 0; i < KW / 32; i++) k[i*32 +: 32] = $urandom;
    return k;
  endfunction

  task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs == exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the core idle; returns at the negedge after the accept edge.
  task automatic offer(input logic [63:0] d, input logic [KW-1:0] k, input logic m);
    check1("in_ready_before_offer", in_ready, 1'b1);
    in_valid = 1'b1;
    in_data  = d;
    key      = k;
    in_mode  = m;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Counts clock edges after the accept edge until out_valid is seen.
  task automatic wait_result();
    int lat;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!out_valid && lat < 200);
    check_int("latency", lat, RN);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check1("out_valid_after_take", out_valid, 1'b0);
  endtask

  initial begin
    logic [63:0]   d, d2, e;
    logic [KW-1:0] k, k2;
    logic          m;

    rst_n = 1'b0;
    in_valid = 1'b0; in_mode = 1'b0; in_data = '0; key = '0; out_ready = 1'b0;
    in_valid_1 = 1'b0; in_mode_1 = 1'b0; in_data_1 = '0; key_1 = '0; out_ready_1 = 1'b0;
    #12;
    check1("rst_out_valid", out_valid, 1'b0);
    check64("rst_out_data", out_data, 64'h0);
    check1("rst_out_mode", out_mode, 1'b0);
    check1("rst_busy", busy, 1'b0);
    check1("rst_out_valid_1", out_valid_1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check1("in_ready_after_rst", in_ready, 1'b1);

    // Single slice, single round: zero in gives all ones, valid two cycles after accept.
    in_valid_1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid_1 = 1'b0;
    check1("one_round_not_yet_valid", out_valid_1, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check1("one_round_valid", out_valid_1, 1'b1);
    check64("one_round_data", out_data_1, 64'hFFFF_FFFF_FFFF_FFFF);
    out_ready_1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready_1 = 1'b0;
    check1("one_round_taken", out_valid_1, 1'b0);

    // All-zero key and data encrypts to zero.
    offer(64'h0, '0, MODE_ENC);
    check1("busy_in_run", busy, 1'b1);
    check1("in_ready_in_run", in_ready, 1'b0);
    wait_result();
    check64("zero_enc_data", out_data, 64'h0);
    check1("zero_enc_mode", out_mode, MODE_ENC);
    consume();

    // Random round trips.
    for (int n = 0; n < 1000; n++) begin
      d = {$urandom, $urandom};
      k = rand_key();
      e = ref_model(d, k, MODE_ENC);
      offer(d, k, MODE_ENC);
      wait_result();
      check64("rand_enc_data", out_data, e);
      check1("rand_enc_mode", out_mode, MODE_ENC);
      consume();
      offer(e, k, MODE_DEC);
      wait_result();
      check64("rand_dec_data", out_data, d);
      check1("rand_dec_mode", out_mode, MODE_DEC);
      consume();
    end

    // Back-pressure in DONE, then take result and accept next block in one cycle.
    d = {$urandom, $urandom};
    k = rand_key();
    e = ref_model(d, k, MODE_ENC);
    offer(d, k, MODE_ENC);
    wait_result();
    for (int c = 0; c < 50; c++) begin
      @(posedge clk);
      @(negedge clk);
      check1("bp_out_valid", out_valid, 1'b1);
      check64("bp_out_data", out_data, e);
      check1("bp_in_ready", in_ready, 1'b0);
    end
    d2 = {$urandom, $urandom};
    k2 = rand_key();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = d2;
    key       = k2;
    in_mode   = MODE_DEC;
    #1;
    check1("bp_in_ready_with_out_ready", in_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check1("bp_back_to_back_valid", out_valid, 1'b0);
    check1("bp_back_to_back_busy", busy, 1'b1);
    wait_result();
    check64("bp_second_data", out_data, ref_model(d2, k2, MODE_DEC));
    check1("bp_second_mode", out_mode, MODE_DEC);
    consume();

    // Key and mode changed right after accept must not affect the block.
    d = {$urandom, $urandom};
    k = rand_key();
    m = 1'($urandom_range(0, 1));
    offer(d, k, m);
    key     = ~k;
    in_mode = ~m;
    in_data = ~d;
    wait_result();
    check64("capture_data", out_data, ref_model(d, k, m));
    check1("capture_mode", out_mode, m);
    consume();

    // Asynchronous reset in the middle of RUN.
    d = {$urandom, $urandom};
    k = rand_key();
    offer(d, k, MODE_DEC);
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check1("abort_out_valid", out_valid, 1'b0);
    check64("abort_out_data", out_data, 64'h0);
    check1("abort_out_mode", out_mode, 1'b0);
    check1("abort_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check1("abort_in_ready", in_ready, 1'b1);
    check1("abort_still_idle", out_valid, 1'b0);
    d = {$urandom, $urandom};
    k = rand_key();
    offer(d, k, MODE_ENC);
    wait_result();
    check64("after_abort_data", out_data, ref_model(d, k, MODE_ENC));
    consume();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
